// File: rtl/commit_trace_pkg.sv
// Shared record definition for the commit trace buffer.
// Holds the record type codes, the packed record layout and a word-align helper.
package commit_trace_pkg;

    localparam logic TR_GRF = 1'b0;
    localparam logic TR_MEM = 1'b1;

    typedef struct packed {
        logic        typ;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  byteen;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);
    localparam int SEQ_W = 16;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/commit_trace_if.sv
// CPU commit events in, trace records out. out_seq exists only when
// COMMIT_TRACE_SEQ_EN is defined.
interface commit_trace_if;

    logic        w_grf_we;
    logic [4:0]  w_grf_addr;
    logic [31:0] w_grf_wdata;
    logic [31:0] w_inst_addr;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [31:0] m_inst_addr;
    logic        out_valid;
    logic        out_ready;
    logic        out_type;
    logic [31:0] out_pc;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  out_byteen;
`ifdef COMMIT_TRACE_SEQ_EN
    logic [15:0] out_seq;
`endif

    modport master (
        output w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr,
        output m_data_byteen, m_data_addr, m_data_wdata, m_inst_addr,
        output out_ready,
`ifdef COMMIT_TRACE_SEQ_EN
        input  out_seq,
`endif
        input  out_valid, out_type, out_pc, out_addr, out_data, out_byteen
    );

    modport slave (
        input  w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr,
        input  m_data_byteen, m_data_addr, m_data_wdata, m_inst_addr,
        input  out_ready,
`ifdef COMMIT_TRACE_SEQ_EN
        output out_seq,
`endif
        output out_valid, out_type, out_pc, out_addr, out_data, out_byteen
    );

endinterface

// File: rtl/commit_trace_ram.sv
// Trace entry storage: two synchronous write ports, one asynchronous read port.
// The two write addresses are always distinct (consecutive slots).
module commit_trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 101
) (
    input  logic                     clk,
    input  logic                     we_a,
    input  logic [$clog2(DEPTH)-1:0] addr_a,
    input  logic [WIDTH-1:0]         data_a,
    input  logic                     we_b,
    input  logic [$clog2(DEPTH)-1:0] addr_b,
    input  logic [WIDTH-1:0]         data_b,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        if (we_b) mem[addr_b] <= data_b;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buf.sv
// Show-ahead FIFO of CPU commit records (GRF writebacks and stores), up to two per cycle.
// Define COMMIT_TRACE_SEQ_EN to tag each accepted record with a 16-bit sequence number.
module commit_trace_buf
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    commit_trace_if.slave          bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = LW + 1;
`ifdef COMMIT_TRACE_SEQ_EN
    localparam int ENT_W = REC_W + SEQ_W;
`else
    localparam int ENT_W = REC_W;
`endif

    logic [AW-1:0]    wptr, rptr;
    logic             grf_v, mem_v, valid, pop;
    logic [FW-1:0]    free_slots;
    logic [1:0]       n_req, n_acc, n_drop;
    logic [CNT_W:0]   drop_sum;
    trace_rec_t       grf_rec, mem_rec, rec0, rec1, head;
    logic [ENT_W-1:0] ent0, ent1, ent_rd;

    always_comb begin
        grf_v   = bus.w_grf_we && (bus.w_grf_addr != 5'd0);
        mem_v   = |bus.m_data_byteen;
        grf_rec = '{typ: TR_GRF, pc: bus.w_inst_addr, addr: {27'b0, bus.w_grf_addr},
                    data: bus.w_grf_wdata, byteen: 4'hF};
        mem_rec = '{typ: TR_MEM, pc: bus.m_inst_addr, addr: word_align(bus.m_data_addr),
                    data: bus.m_data_wdata, byteen: bus.m_data_byteen};
        // GRF belongs to the older instruction, so it takes the first slot
        rec0    = grf_v ? grf_rec : mem_rec;
        rec1    = mem_rec;
        valid   = (level != '0);
        pop     = valid && bus.out_ready;
        free_slots = FW'(DEPTH) - FW'(level) + FW'(pop);
        n_req   = {1'b0, grf_v} + {1'b0, mem_v};
        // Truncating acceptance drops the trailing (MEM) record first
        if (free_slots >= FW'(n_req)) n_acc = n_req;
        else                          n_acc = free_slots[1:0];
        n_drop   = n_req - n_acc;
        drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);
    end

`ifdef COMMIT_TRACE_SEQ_EN
    logic [SEQ_W-1:0] seq_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) seq_cnt <= '0;
        else        seq_cnt <= seq_cnt + SEQ_W'(n_acc);
    end

    assign ent0        = {seq_cnt, rec0};
    assign ent1        = {seq_cnt + 16'd1, rec1};
    assign bus.out_seq = valid ? ent_rd[ENT_W-1:REC_W] : '0;
`else
    assign ent0 = rec0;
    assign ent1 = rec1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            wptr  <= wptr + AW'(n_acc);
            rptr  <= rptr + AW'(pop);
            level <= level + LW'(n_acc) - LW'(pop);
            if (n_drop != 2'd0) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            end
        end
    end

    commit_trace_ram #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_ram (
        .clk    (clk),
        .we_a   (n_acc != 2'd0),
        .addr_a (wptr),
        .data_a (ent0),
        .we_b   (n_acc == 2'd2),
        .addr_b (wptr + AW'(1)),
        .data_b (ent1),
        .raddr  (rptr),
        .rdata  (ent_rd)
    );

    assign head           = valid ? trace_rec_t'(ent_rd[REC_W-1:0]) : '0;
    assign bus.out_valid  = valid;
    assign bus.out_type   = head.typ;
    assign bus.out_pc     = head.pc;
    assign bus.out_addr   = head.addr;
    assign bus.out_data   = head.data;
    assign bus.out_byteen = head.byteen;

endmodule

// File: doc/commit_trace_buf.md
COMMIT_TRACE_BUF -- requirements
Module: commit_trace_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, 4..256).
REQ-002 SHALL have parameter CNT_W, default 16, width of the dropped-record counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports w_grf_we/w_grf_addr/w_grf_wdata/w_inst_addr  input  1/5/32/32  CPU register-writeback event.
REQ-006 SHALL have ports m_data_byteen/m_data_addr/m_data_wdata/m_inst_addr  input  4/32/32/32  CPU data-store event.
REQ-007 SHALL have ports out_valid  output  1, and out_ready  input  1  for the consumer handshake.
REQ-008 SHALL have ports out_type/out_pc/out_addr/out_data/out_byteen  output  1/32/32/32/4  head record.
REQ-009 SHALL have ports level  output  $clog2(DEPTH)+1  occupied entries; overflow  output  1  sticky drop flag; drop_cnt  output  CNT_W  saturating count of dropped records.

Function
REQ-010 SHALL form a GRF record (type 0) when w_grf_we=1 and w_grf_addr!=0: pc=w_inst_addr, addr={27'b0,w_grf_addr}, data=w_grf_wdata, byteen=4'hF.
REQ-011 SHALL form a MEM record (type 1) when |m_data_byteen: pc=m_inst_addr, addr=m_data_addr&32'hFFFFFFFC, data=m_data_wdata, byteen=m_data_byteen (raw, no merge).
REQ-012 SHALL accept 0, 1 or 2 records per cycle; when both exist, the GRF record (older instruction) SHALL occupy the earlier FIFO slot.
REQ-013 SHALL pop the head when out_valid && out_ready at the rising edge.
REQ-014 SHALL compute free slots as DEPTH-level+(pop?1:0), so a full FIFO popped in the same cycle accepts one record.
REQ-015 SHALL, when records exceed free slots, keep them in order up to the free count, drop the remainder (MEM first), set overflow, and add the dropped count to drop_cnt, saturating at all-ones.
REQ-016 SHALL present a pushed record on out_* with out_valid=1 starting the cycle after the push edge (1-cycle latency, show-ahead).
REQ-017 SHALL drive out_type/out_pc/out_addr/out_data/out_byteen to 0 whenever out_valid=0.
REQ-018 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-019 SHALL wrap read/write pointers modulo DEPTH; level SHALL never exceed DEPTH.
REQ-020 SHALL clear overflow only by reset.

Reset
REQ-021 SHALL, on reset low (any time, asynchronously), clear pointers, level, overflow, drop_cnt and the sequence counter; out_valid=0; all out_* = 0.
REQ-022 SHALL discard events presented while reset is low; events in flight when reset asserts mid-operation are lost; the first push SHALL occur on the first edge with reset high.

Configuration
REQ-023 SHALL, with COMMIT_TRACE_SEQ_EN defined, add output out_seq[15:0] carrying a per-record sequence number assigned at push, starting at 0, incrementing per accepted record, wrapping at 16'hFFFF->0; dropped records SHALL NOT consume numbers.
REQ-024 SHALL, without COMMIT_TRACE_SEQ_EN, omit out_seq and the counter; all other behaviour SHALL be identical.

Structure
REQ-025 SHALL take the record type constants (TR_GRF=0, TR_MEM=1) and the packed record struct (type, pc, addr, data, byteen) from shared package commit_trace_pkg.
REQ-026 SHALL instantiate one sub-module, commit_trace_ram: a DEPTH x record-width storage array with two write ports and one asynchronous read port.

Verification
REQ-027 Bench: single GRF write $5<=32'h0000_1234 at pc 32'h3004 -> next cycle out_valid=1, type=0, addr=5, data=32'h1234, byteen=F.
REQ-028 Bench: same-cycle GRF write ($3, pc 32'h3008) and sb at 32'h0000_0013 (byteen=4'b1000, pc 32'h300C) -> two records: first GRF at pc 32'h3008, second MEM with addr=32'h10, byteen=8.
REQ-029 Bench: GRF write to $0 with we=1 -> no record; level stays 0.
REQ-030 Bench: out_ready=0, DEPTH=16, 17 single events -> level=16, overflow=1, drop_cnt=1; then one dual event with out_ready=1 -> one accepted, drop_cnt=2.
REQ-031 Bench: reset pulsed low mid-stream with level=5 -> immediately level=0, out_valid=0, overflow=0, drop_cnt=0.
REQ-032 Bench: with COMMIT_TRACE_SEQ_EN defined, 3 records pushed -> out_seq 0,1,2 in pop order.
